dct_mb_scheduler: RTL and testbench
===================================

DCT_MB_SCHEDULER -- requirements
Module: dct_mb_scheduler

Interface
REQ-001 Parameter NUM_BLOCKS, default 6, sets the number of 8x8 blocks per macroblock (4 luma + 2 chroma).
REQ-002 Parameter TIMEOUT_CYCLES, default 8192, sets the maximum cycles spent waiting on the transform engine for one block.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port mb_start, input, 1 bit: request to transform one macroblock.
REQ-006 Port mb_is_intra, input, 1 bit: intra flag, sampled with mb_start.
REQ-007 Port mb_busy, output, 1 bit: a macroblock is in progress.
REQ-008 Port mb_done, output, 1 bit: one-cycle pulse when all blocks are accepted downstream.
REQ-009 Port blk_sel, output, 3 bits: index of the block routed to the engine's data input mux.
REQ-010 Port tf_do_compute, output, 1 bit: one-cycle start pulse to the transform engine.
REQ-011 Port tf_is_intra, output, 1 bit: intra flag to the engine, held for the whole macroblock.
REQ-012 Port tf_computing, input, 1 bit: the engine's computing status.
REQ-013 Port out_valid, output, 1 bit: the engine's data_out holds a finished block.
REQ-014 Port out_ready, input, 1 bit: downstream (entropy coder) accepts the block.
REQ-015 Port out_blk_idx, output, 3 bits: index of the presented block.
REQ-016 Port out_last, output, 1 bit: the presented block is block NUM_BLOCKS-1.
REQ-017 Port err_timeout, output, 1 bit: sticky engine-timeout flag.

Function
REQ-018 States: IDLE, ISSUE, WAIT_START, WAIT_DONE, PRESENT, DONE.
REQ-019 IDLE: on mb_start=1, latch mb_is_intra into tf_is_intra, set blk_sel=0, clear err_timeout, and go to ISSUE.
REQ-020 mb_start SHALL be ignored in every state other than IDLE; no queuing.
REQ-021 ISSUE: assert tf_do_compute for exactly one cycle, clear the timeout counter, and go to WAIT_START.
REQ-022 WAIT_START: on tf_computing=1, go to WAIT_DONE.
REQ-023 WAIT_DONE: on tf_computing=0, go to PRESENT; block completion is this 1->0 edge only, because the engine's output_valid is sticky and is not used.
REQ-024 Timeout counter: increments every cycle in WAIT_START and WAIT_DONE; saturates at TIMEOUT_CYCLES.
REQ-025 Timeout: on reaching TIMEOUT_CYCLES-1 in either wait state, set err_timeout=1 and go to IDLE; mb_done is not pulsed.
REQ-026 err_timeout SHALL remain 1 until rst or the next accepted mb_start.
REQ-027 PRESENT: out_valid=1, out_blk_idx=blk_sel, out_last=(blk_sel==NUM_BLOCKS-1).
REQ-028 PRESENT, while out_ready=0: hold out_valid and all outputs stable; no cycle limit applies, and no new tf_do_compute is issued (data_out must not be overwritten).
REQ-029 PRESENT, on out_valid and out_ready both 1 with out_last=0: increment blk_sel and go to ISSUE; the next tf_do_compute is issued on the following cycle.
REQ-030 PRESENT, on out_valid and out_ready both 1 with out_last=1: go to DONE.
REQ-031 DONE: mb_done=1 for one cycle, then go to IDLE.
REQ-032 mb_busy=1 in every state except IDLE.
REQ-033 out_valid and tf_do_compute SHALL be registered outputs; they are never both 1 in the same cycle.
REQ-034 blk_sel SHALL stay constant from ISSUE through the handshake in PRESENT.

Reset
REQ-035 While rst=1: state=IDLE, and blk_sel, tf_do_compute, tf_is_intra, out_valid, out_blk_idx, out_last, mb_busy, mb_done, err_timeout and the timeout counter are all 0.
REQ-036 rst asserted mid-macroblock SHALL abort immediately with no mb_done pulse; the engine is reset by the same rst.

Verification
REQ-037 Nominal: mb_start=1 with mb_is_intra=1; engine model holds computing for 4100 cycles per block; out_ready tied to 1 -> 6 tf_do_compute pulses, out_blk_idx 0..5, out_last only at index 5, tf_is_intra=1 throughout, one mb_done pulse.
REQ-038 Backpressure: out_ready=0 for 20 cycles at block 2 -> out_valid held with out_blk_idx=2, no tf_do_compute during the stall, sequence resumes after out_ready=1.
REQ-039 Start while busy: mb_start pulsed during block 3 -> ignored; exactly 6 blocks and 1 mb_done.
REQ-040 Timeout: engine never raises computing -> err_timeout=1 after 8192 cycles, state returns to IDLE, no mb_done; a subsequent mb_start clears err_timeout.
REQ-041 Async reset: rst asserted mid-WAIT_DONE between clock edges -> all outputs 0 before the next edge; a new mb_start starts from blk_sel=0.
REQ-042 Back-to-back: mb_start asserted in the cycle after mb_done -> accepted, new mb_is_intra=0 latched, 6 more blocks produced.

Source files
------------

// File: rtl/dct_mb_scheduler.sv
// dct_mb_scheduler
// Sequences the blocks of one macroblock through a transform engine. Each
// block is started with a one-cycle pulse. Completion is taken from the
// falling edge of the engine's computing status. The finished block is then
// presented downstream with a valid/ready handshake before the next block
// is issued.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   mb_start          request one macroblock (only honoured when idle)
//   mb_is_intra       intra flag, sampled together with mb_start
//   mb_busy           a macroblock is in progress
//   mb_done           one-cycle pulse after the last block is accepted
//   blk_sel           block index steering the engine's input mux
//   tf_do_compute     one-cycle start pulse to the engine
//   tf_is_intra       intra flag to the engine, held per macroblock
//   tf_computing      engine computing status
//   out_valid         engine output holds a finished block
//   out_ready         downstream accepts the presented block
//   out_blk_idx       index of the presented block
//   out_last          presented block is the final one of the macroblock
//   err_timeout       sticky engine-timeout flag
module dct_mb_scheduler #(
  parameter int NUM_BLOCKS     = 6,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mb_start,
  input  logic       mb_is_intra,
  output logic       mb_busy,
  output logic       mb_done,
  output logic [2:0] blk_sel,
  output logic       tf_do_compute,
  output logic       tf_is_intra,
  input  logic       tf_computing,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_blk_idx,
  output logic       out_last,
  output logic       err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [2:0]       LAST_BLK = 3'(NUM_BLOCKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_DONE,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       blk_sel_q, blk_sel_d;
  logic             tf_do_compute_q, tf_do_compute_d;
  logic             tf_is_intra_q, tf_is_intra_d;
  logic             out_valid_q, out_valid_d;
  logic [2:0]       out_blk_idx_q, out_blk_idx_d;
  logic             out_last_q, out_last_d;
  logic             mb_busy_q, mb_busy_d;
  logic             mb_done_q, mb_done_d;
  logic             err_timeout_q, err_timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  // Counter saturates rather than wrapping, even though the timeout exit
  // normally leaves the wait states before saturation is reached.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d         = state_q;
    blk_sel_d       = blk_sel_q;
    tf_do_compute_d = 1'b0;
    tf_is_intra_d   = tf_is_intra_q;
    out_valid_d     = out_valid_q;
    out_blk_idx_d   = out_blk_idx_q;
    out_last_d      = out_last_q;
    mb_busy_d       = mb_busy_q;
    mb_done_d       = 1'b0;
    err_timeout_d   = err_timeout_q;
    cnt_d           = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (mb_start) begin
          state_d         = S_ISSUE;
          tf_is_intra_d   = mb_is_intra;
          blk_sel_d       = 3'd0;
          err_timeout_d   = 1'b0;
          mb_busy_d       = 1'b1;
          tf_do_compute_d = 1'b1;  // registered pulse coincides with ISSUE
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        // An engine event in the same cycle as the deadline wins.
        if (tf_computing) begin
          cnt_d   = cnt_inc;
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_timeout_d = 1'b1;
          mb_busy_d     = 1'b0;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT_DONE: begin
        // The engine's own valid flag is sticky, so completion is the 1->0
        // edge of computing, seen here as computing going low.
        if (!tf_computing) begin
          out_valid_d   = 1'b1;
          out_blk_idx_d = blk_sel_q;
          out_last_d    = (blk_sel_q == LAST_BLK);
          state_d       = S_PRESENT;
        end else if (cnt_q == CNT_LAST) begin
          err_timeout_d = 1'b1;
          mb_busy_d     = 1'b0;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_PRESENT: begin
        // Hold everything until accepted; issuing now would overwrite the
        // engine's output buffer.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            mb_done_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            blk_sel_d       = blk_sel_q + 3'd1;
            tf_do_compute_d = 1'b1;
            state_d         = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        mb_busy_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        mb_busy_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      blk_sel_q       <= 3'd0;
      tf_do_compute_q <= 1'b0;
      tf_is_intra_q   <= 1'b0;
      out_valid_q     <= 1'b0;
      out_blk_idx_q   <= 3'd0;
      out_last_q      <= 1'b0;
      mb_busy_q       <= 1'b0;
      mb_done_q       <= 1'b0;
      err_timeout_q   <= 1'b0;
      cnt_q           <= '0;
    end else begin
      state_q         <= state_d;
      blk_sel_q       <= blk_sel_d;
      tf_do_compute_q <= tf_do_compute_d;
      tf_is_intra_q   <= tf_is_intra_d;
      out_valid_q     <= out_valid_d;
      out_blk_idx_q   <= out_blk_idx_d;
      out_last_q      <= out_last_d;
      mb_busy_q       <= mb_busy_d;
      mb_done_q       <= mb_done_d;
      err_timeout_q   <= err_timeout_d;
      cnt_q           <= cnt_d;
    end
  end

  assign mb_busy       = mb_busy_q;
  assign mb_done       = mb_done_q;
  assign blk_sel       = blk_sel_q;
  assign tf_do_compute = tf_do_compute_q;
  assign tf_is_intra   = tf_is_intra_q;
  assign out_valid     = out_valid_q;
  assign out_blk_idx   = out_blk_idx_q;
  assign out_last      = out_last_q;
  assign err_timeout   = err_timeout_q;

endmodule

// File: tb/tb_dct_mb_scheduler.sv
// Testbench for dct_mb_scheduler: behavioural transform engine, scoreboard
// of expected presented blocks, directed scenario sequence.
module tb_dct_mb_scheduler;

  logic       clk;
  logic       rst;
  logic       mb_start;
  logic       mb_is_intra;
  logic       mb_busy;
  logic       mb_done;
  logic [2:0] blk_sel;
  logic       tf_do_compute;
  logic       tf_is_intra;
  logic       tf_computing;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_blk_idx;
  logic       out_last;
  logic       err_timeout;

  dct_mb_scheduler #(.NUM_BLOCKS(6), .TIMEOUT_CYCLES(8192)) dut (
    .clk          (clk),
    .rst          (rst),
    .mb_start     (mb_start),
    .mb_is_intra  (mb_is_intra),
    .mb_busy      (mb_busy),
    .mb_done      (mb_done),
    .blk_sel      (blk_sel),
    .tf_do_compute(tf_do_compute),
    .tf_is_intra  (tf_is_intra),
    .tf_computing (tf_computing),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_blk_idx  (out_blk_idx),
    .out_last     (out_last),
    .err_timeout  (err_timeout)
  );

  typedef struct packed {
    logic [2:0] idx;
    logic       last;
    logic       intra;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   n_compute = 0;
  int   n_done    = 0;
  int   n_pop     = 0;
  int   eng_lat   = 4100;
  bit   eng_never = 1'b0;
  int   eng_cnt   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transform engine: raises computing on the start pulse, holds it for
  // eng_lat cycles, never responds while eng_never is set.
  initial begin
    tf_computing = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tf_computing = 1'b0;
        eng_cnt      = 0;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) tf_computing = 1'b0;
      end else if (tf_do_compute && !eng_never) begin
        tf_computing = 1'b1;
        eng_cnt      = eng_lat;
      end
    end
  end

  // Output monitor: counts pulses and checks every accepted block against
  // the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tf_do_compute === 1'b1) n_compute++;
        if (mb_done === 1'b1) n_done++;
        chk("valid_compute_excl", 32'(out_valid & tf_do_compute), 0);
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          chk("sb_avail", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_pop++;
            chk("blk_idx", 32'(out_blk_idx), 32'(e.idx));
            chk("blk_last", 32'(out_last), 32'(e.last));
            chk("blk_intra", 32'(tf_is_intra), 32'(e.intra));
          end
        end
      end
    end
  end

  task automatic push_mb(input logic intra);
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      e.idx   = 3'(i);
      e.last  = (i == 5);
      e.intra = intra;
      exp_q.push_back(e);
    end
  endtask

  task automatic start_mb(input logic intra, input bit push);
    if (push) push_mb(intra);
    mb_is_intra = intra;
    mb_start    = 1'b1;
    step();
    mb_start    = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k;
    k = 0;
    while (mb_done !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(mb_done), 1);
  endtask

  task automatic check_idle_zero(input string pfx);
    chk({pfx, "_busy"}, 32'(mb_busy), 0);
    chk({pfx, "_done"}, 32'(mb_done), 0);
    chk({pfx, "_blk_sel"}, 32'(blk_sel), 0);
    chk({pfx, "_compute"}, 32'(tf_do_compute), 0);
    chk({pfx, "_intra"}, 32'(tf_is_intra), 0);
    chk({pfx, "_valid"}, 32'(out_valid), 0);
    chk({pfx, "_idx"}, 32'(out_blk_idx), 0);
    chk({pfx, "_last"}, 32'(out_last), 0);
    chk({pfx, "_err"}, 32'(err_timeout), 0);
  endtask

  task automatic clear_counts();
    n_compute = 0;
    n_done    = 0;
    n_pop     = 0;
  endtask

  initial begin
    int k;
    int c0;
    rst         = 1'b1;
    mb_start    = 1'b0;
    mb_is_intra = 1'b0;
    out_ready   = 1'b1;
    repeat (3) step();
    check_idle_zero("reset");
    rst = 1'b0;
    step();

    // Nominal macroblock, intra, slow engine.
    clear_counts();
    eng_lat = 4100;
    start_mb(1'b1, 1'b1);
    chk("nom_busy", 32'(mb_busy), 1);
    chk("nom_intra", 32'(tf_is_intra), 1);
    chk("nom_first_pulse", 32'(tf_do_compute), 1);
    wait_done(30000, "nom_done_seen");
    step();
    chk("nom_computes", 32'(n_compute), 6);
    chk("nom_dones", 32'(n_done), 1);
    chk("nom_pops", 32'(n_pop), 6);
    chk("nom_sb_empty", 32'(exp_q.size()), 0);
    chk("nom_idle", 32'(mb_busy), 0);

    // Backpressure on block 2.
    clear_counts();
    eng_lat = 20;
    start_mb(1'b1, 1'b1);
    k = 0;
    while (!(tf_do_compute === 1'b1 && blk_sel === 3'd2) && k < 500) begin
      step();
      k++;
    end
    chk("bp_issue2_seen", 32'(k < 500), 1);
    out_ready = 1'b0;
    k = 0;
    while (out_valid !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    chk("bp_valid_seen", 32'(k < 200), 1);
    c0 = n_compute;
    repeat (20) step();
    chk("bp_valid_held", 32'(out_valid), 1);
    chk("bp_idx_held", 32'(out_blk_idx), 2);
    chk("bp_last_held", 32'(out_last), 0);
    chk("bp_blk_sel", 32'(blk_sel), 2);
    chk("bp_no_compute", 32'(n_compute), 32'(c0));
    out_ready = 1'b1;
    wait_done(2000, "bp_done_seen");
    step();
    chk("bp_computes", 32'(n_compute), 6);
    chk("bp_dones", 32'(n_done), 1);
    chk("bp_sb_empty", 32'(exp_q.size()), 0);

    // Start pulse while busy on block 3 must be ignored.
    clear_counts();
    start_mb(1'b1, 1'b1);
    k = 0;
    while (!(tf_computing === 1'b1 && blk_sel === 3'd3) && k < 500) begin
      step();
      k++;
    end
    chk("busy_blk3_seen", 32'(k < 500), 1);
    mb_is_intra = 1'b0;
    mb_start    = 1'b1;
    step();
    mb_start    = 1'b0;
    chk("busy_intra_kept", 32'(tf_is_intra), 1);
    wait_done(2000, "busy_done_seen");
    repeat (10) step();
    chk("busy_computes", 32'(n_compute), 6);
    chk("busy_dones", 32'(n_done), 1);
    chk("busy_pops", 32'(n_pop), 6);
    chk("busy_idle_after", 32'(mb_busy), 0);

    // Back-to-back macroblocks, second one inter.
    clear_counts();
    start_mb(1'b1, 1'b1);
    wait_done(2000, "b2b_done1_seen");
    step();
    start_mb(1'b0, 1'b1);
    chk("b2b_accept_busy", 32'(mb_busy), 1);
    chk("b2b_intra0", 32'(tf_is_intra), 0);
    chk("b2b_blk0", 32'(blk_sel), 0);
    chk("b2b_pulse", 32'(tf_do_compute), 1);
    wait_done(2000, "b2b_done2_seen");
    step();
    chk("b2b_computes", 32'(n_compute), 12);
    chk("b2b_dones", 32'(n_done), 2);
    chk("b2b_pops", 32'(n_pop), 12);
    chk("b2b_sb_empty", 32'(exp_q.size()), 0);

    // Engine never starts: timeout fires exactly at the deadline.
    clear_counts();
    eng_never = 1'b1;
    start_mb(1'b1, 1'b0);
    repeat (8192) step();
    chk("to_err_before", 32'(err_timeout), 0);
    chk("to_busy_before", 32'(mb_busy), 1);
    step();
    chk("to_err_set", 32'(err_timeout), 1);
    chk("to_busy_clear", 32'(mb_busy), 0);
    repeat (5) step();
    chk("to_err_sticky", 32'(err_timeout), 1);
    chk("to_no_done", 32'(n_done), 0);
    chk("to_one_compute", 32'(n_compute), 1);
    chk("to_no_valid", 32'(n_pop), 0);
    eng_never = 1'b0;
    clear_counts();
    start_mb(1'b1, 1'b1);
    chk("to_err_cleared", 32'(err_timeout), 0);
    wait_done(2000, "to_recover_done");
    step();
    chk("to_recover_pops", 32'(n_pop), 6);

    // Asynchronous reset in the middle of WAIT_DONE.
    clear_counts();
    start_mb(1'b1, 1'b1);
    k = 0;
    while (!(tf_computing === 1'b1 && blk_sel === 3'd1) && k < 500) begin
      step();
      k++;
    end
    chk("ar_wait_seen", 32'(k < 500), 1);
    #2;
    rst = 1'b1;
    #1;
    check_idle_zero("async_rst");
    exp_q.delete();
    repeat (3) step();
    rst = 1'b0;
    step();
    start_mb(1'b0, 1'b1);
    chk("ar_restart_blk0", 32'(blk_sel), 0);
    chk("ar_restart_intra", 32'(tf_is_intra), 0);
    wait_done(2000, "ar_done_seen");
    step();
    chk("ar_dones", 32'(n_done), 1);
    chk("ar_pops", 32'(n_pop), 7);
    chk("ar_computes", 32'(n_compute), 8);
    chk("ar_sb_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
